// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ
// byte producers. A grant is held for a whole message, so messages never
// interleave on the line. A stalled message is dropped after MAX_GAP idle
// cycles.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int MAX_GAP = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [W-1:0]             tx_data,
  output logic                     tx_send,
  input  logic                     tx_rdy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     abort
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MAX_GAP);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [GW-1:0] gap_cnt;
  logic          last_q;

  logic          found;
  logic [IW-1:0] pick;
  logic          sel_valid;
  logic          sel_last;
  logic [W-1:0]  sel_data;
  logic [IW-1:0] grant_next;
  logic          handshake;

  // Round-robin pick: first valid index at or above ptr, else wrap to the lowest valid index below it
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (IW'(i) >= ptr)) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end

  // Route the granted requester's valid/data/last onto a single set of wires
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*W +: W];
      end
    end
  end

  // Pointer value that places the current grant last in the next round
  always_comb begin
    if (grant_id == IW'(N_REQ - 1)) begin
      grant_next = '0;
    end else begin
      grant_next = grant_id + IW'(1);
    end
  end

  // Only the granted requester may see ready, and only while the transmitter is idle
  always_comb begin
    req_ready = '0;
    handshake = 1'b0;
    if (state == S_LOAD) begin
      handshake = tx_rdy && sel_valid;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_id == IW'(i)) begin
          req_ready[i] = tx_rdy && req_valid[i];
        end
      end
    end
  end

  assign busy = (state != S_IDLE);

  // Control FSM: grant lock, round-robin pointer, gap timeout and abort pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gap_cnt  <= '0;
      grant_id <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id <= pick;
            gap_cnt  <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            gap_cnt <= '0;
            state   <= S_WAIT_ACK;
          end else if (!sel_valid) begin
            if (gap_cnt == GAP_MAX) begin
              abort <= 1'b1;
              ptr   <= grant_next;
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        S_WAIT_ACK: begin
          if (!tx_rdy) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_rdy) begin
            if (last_q) begin
              ptr   <= grant_next;
              state <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: capture the byte and end-of-message flag on the handshake, pulse tx_send once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data <= '0;
      tx_send <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      if (handshake) begin
        tx_data <= sel_data;
        tx_send <= 1'b1;
        last_q  <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: producer and transmitter models with
// a log of every byte put on the line, checked against hand-computed order.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_rdy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        abort;

  uart_tx_arbiter #(
    .N_REQ   (4),
    .W       (8),
    .MAX_GAP (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_rdy    (tx_rdy),
    .grant_id  (grant_id),
    .busy      (busy),
    .abort     (abort)
  );

  localparam int FRAME = 3;

  int checks = 0;
  int errors = 0;

  // producer model state
  logic [7:0] pdata [4][4];
  logic       plast [4][4];
  int         plen  [4];
  int         pidx  [4];

  // line log
  logic [7:0] sent_data [64];
  int         sent_src  [64];
  int         n_sent = 0;
  int         n_hs = 0;
  int         n_abort = 0;
  int         abort_cyc = 0;
  int         rdy_rise_cyc = 0;
  int         cyc = 0;
  int         frame_cnt = 0;
  bit         model_en = 1'b1;
  logic [3:0] hs;

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pidx[i] < plen[i]) begin
        req_valid[i]      = 1'b1;
        req_data[i*8 +: 8] = pdata[i][pidx[i]];
        req_last[i]       = plast[i][pidx[i]];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  // load requester r with n bytes (first byte in bits [7:0]) and per-byte last flags
  task automatic applyStimulus(input int r, input int n, input logic [31:0] bytes, input logic [3:0] lastmask);
    for (int k = 0; k < n; k++) begin
      pdata[r][k] = bytes[k*8 +: 8];
      plast[r][k] = lastmask[k];
    end
    plen[r] = n;
    pidx[r] = 0;
    drive();
  endtask

  // one clock: sample handshakes before the edge, then log outputs and update models after it
  task automatic step();
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_send && n_sent < 64) begin
      sent_data[n_sent] = tx_data;
      sent_src[n_sent]  = int'(grant_id);
      n_sent++;
    end
    if (abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        pidx[i]++;
        n_hs++;
      end
    end
    drive();
    if (model_en) begin
      if (tx_send) begin
        tx_rdy    = 1'b0;
        frame_cnt = FRAME;
      end else if (!tx_rdy && frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin
          tx_rdy       = 1'b1;
          rdy_rise_cyc = cyc;
        end
      end
    end
  endtask

  task automatic waitSends(input int target, input int budget, input string tag);
    int n = 0;
    while (n_sent < target && n < budget) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(n_sent >= target), 32'd1);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(!busy), 32'd1);
  endtask

  task automatic checkSend(input string tag, input int k, input int src, input logic [7:0] data);
    checkOutput({tag, "_src"}, 32'(sent_src[k]), 32'(src));
    checkOutput({tag, "_data"}, 32'(sent_data[k]), 32'(data));
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    tx_rdy    = 1'b1;
    frame_cnt = 0;
    model_en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      plen[i] = 0;
      pidx[i] = 0;
    end
    drive();
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_send", 32'(tx_send), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_abort", 32'(abort), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int ready_seen;
    int sent0;
    int abort0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_rdy    = 1'b1;
    hs        = '0;

    $display("[TB] reset");
    doReset();

    $display("[TB] single byte from req1");
    base = n_sent;
    applyStimulus(1, 1, 32'h0000_00A5, 4'b0001);
    step();
    checkOutput("t1_grant", 32'(grant_id), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_ready", 32'(req_ready), 32'h2);
    checkOutput("t1_send_early", 32'(tx_send), 32'd0);
    step();
    checkOutput("t1_send", 32'(tx_send), 32'd1);
    checkOutput("t1_txdata", 32'(tx_data), 32'hA5);
    step();
    checkOutput("t1_send_pulse", 32'(tx_send), 32'd0);
    waitIdle(20, "t1_idle");
    // pointer now 2: with req0 and req2 pending, req2 goes first
    applyStimulus(0, 1, 32'h0000_0010, 4'b0001);
    applyStimulus(2, 1, 32'h0000_0020, 4'b0001);
    waitSends(base + 3, 40, "t1_rr_timeout");
    checkSend("t1_s0", base, 1, 8'hA5);
    checkSend("t1_s1", base + 1, 2, 8'h20);
    checkSend("t1_s2", base + 2, 0, 8'h10);
    waitIdle(20, "t1_idle2");

    $display("[TB] all four requesters");
    doReset();
    base = n_sent;
    applyStimulus(0, 2, 32'h0000_4440, 4'b0011);
    applyStimulus(1, 1, 32'h0000_0041, 4'b0001);
    applyStimulus(2, 1, 32'h0000_0042, 4'b0001);
    applyStimulus(3, 1, 32'h0000_0043, 4'b0001);
    waitSends(base + 5, 80, "t2_timeout");
    checkSend("t2_s0", base, 0, 8'h40);
    checkSend("t2_s1", base + 1, 1, 8'h41);
    checkSend("t2_s2", base + 2, 2, 8'h42);
    checkSend("t2_s3", base + 3, 3, 8'h43);
    checkSend("t2_s4", base + 4, 0, 8'h44);
    waitIdle(20, "t2_idle");
    checkOutput("t2_hs_vs_send", 32'(n_hs), 32'(n_sent));

    $display("[TB] three byte message with competing requester");
    base = n_sent;
    applyStimulus(2, 3, 32'h0033_2211, 4'b0100);
    applyStimulus(0, 1, 32'h0000_0055, 4'b0001);
    waitSends(base + 4, 80, "t3_timeout");
    checkSend("t3_s0", base, 2, 8'h11);
    checkSend("t3_s1", base + 1, 2, 8'h22);
    checkSend("t3_s2", base + 2, 2, 8'h33);
    checkSend("t3_s3", base + 3, 0, 8'h55);
    waitIdle(20, "t3_idle");

    $display("[TB] gap timeout on req3");
    base = n_sent;
    abort0 = n_abort;
    applyStimulus(3, 1, 32'h0000_0077, 4'b0000);
    applyStimulus(0, 1, 32'h0000_0088, 4'b0001);
    begin
      int n = 0;
      while (n_abort == abort0 && n < 60) begin
        step();
        n++;
      end
    end
    checkOutput("t4_abort_seen", 32'(n_abort - abort0), 32'd1);
    checkOutput("t4_abort_delay", 32'(abort_cyc - rdy_rise_cyc), 32'd10);
    checkOutput("t4_sent_before", 32'(n_sent - base), 32'd1);
    step();
    checkOutput("t4_abort_pulse", 32'(abort), 32'd0);
    waitSends(base + 2, 40, "t4_timeout");
    checkSend("t4_s0", base, 3, 8'h77);
    checkSend("t4_s1", base + 1, 0, 8'h88);
    checkOutput("t4_abort_count", 32'(n_abort - abort0), 32'd1);
    waitIdle(20, "t4_idle");

    $display("[TB] transmitter held busy in LOAD");
    base = n_sent;
    abort0 = n_abort;
    model_en = 1'b0;
    tx_rdy = 1'b0;
    applyStimulus(1, 1, 32'h0000_0099, 4'b0001);
    step();
    checkOutput("t5_grant", 32'(grant_id), 32'd1);
    ready_seen = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (req_ready != 4'h0) ready_seen++;
    end
    checkOutput("t5_no_ready", 32'(ready_seen), 32'd0);
    checkOutput("t5_no_send", 32'(n_sent - base), 32'd0);
    checkOutput("t5_no_abort", 32'(n_abort - abort0), 32'd0);
    tx_rdy = 1'b1;
    model_en = 1'b1;
    #1;
    checkOutput("t5_ready", 32'(req_ready), 32'h2);
    step();
    checkOutput("t5_send", 32'(tx_send), 32'd1);
    checkOutput("t5_txdata", 32'(tx_data), 32'h99);
    waitIdle(20, "t5_idle");

    $display("[TB] reset during WAIT_DONE");
    base = n_sent;
    applyStimulus(2, 2, 32'h0000_C2C1, 4'b0010);
    waitSends(base + 1, 20, "t6_first_timeout");
    step();
    sent0 = n_sent;
    rst_n = 1'b0;
    step();
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_send", 32'(tx_send), 32'd0);
    checkOutput("t6_grant", 32'(grant_id), 32'd0);
    checkOutput("t6_ready", 32'(req_ready), 32'd0);
    checkOutput("t6_no_extra", 32'(n_sent - sent0), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1, 1, 32'h0000_00B1, 4'b0001);
    waitSends(base + 3, 60, "t6_timeout");
    checkSend("t6_s0", base, 2, 8'hC1);
    checkSend("t6_s1", base + 1, 1, 8'hB1);
    checkSend("t6_s2", base + 2, 2, 8'hC2);
    waitIdle(20, "t6_idle");
    checkOutput("t6_hs_vs_send", 32'(n_hs), 32'(n_sent));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
